// File: rtl/bp_pkg.sv
// Shared branch-predictor constants, BTB entry layout and saturating-counter helpers.
package bp_pkg;
   localparam int unsigned BP_BIMODAL   = 0;
   localparam int unsigned BP_GSHARE    = 1;
   localparam int unsigned BP_XLEN      = 32;
   localparam int unsigned BP_CTR_MAX_W = 4;

   typedef logic [BP_CTR_MAX_W-1:0] bp_ctr_t;

   typedef struct packed {
      logic               valid;
      logic [BP_XLEN-1:0] tag;
      logic [BP_XLEN-1:0] target;
      logic               is_cond;
   } btb_entry_t;

   function automatic bp_ctr_t ctr_init(input int unsigned bits);
      return BP_CTR_MAX_W'((1 << (bits - 1)) - 1);
   endfunction

   function automatic bp_ctr_t ctr_max(input int unsigned bits);
      return BP_CTR_MAX_W'((1 << bits) - 1);
   endfunction

   // Saturating step: up on taken, down on not-taken, clamped to [0, max].
   function automatic bp_ctr_t ctr_next(input bp_ctr_t ctr, input logic taken,
                                        input int unsigned bits);
      bp_ctr_t res;
      res = ctr;
      if (taken && (ctr != ctr_max(bits))) begin
         res = ctr + bp_ctr_t'(1);
      end else if (!taken && (ctr != '0)) begin
         res = ctr - bp_ctr_t'(1);
      end
      return res;
   endfunction
endpackage

// File: rtl/gshare_predictor_if.sv
// Fetch-side lookup and EX-side resolution signals of the branch predictor.
interface gshare_predictor_if
   import bp_pkg::*;
#(
   parameter int unsigned XLEN     = BP_XLEN,
   parameter int unsigned GHR_BITS = 5
);
   logic                fetch_pc_unused_guard;
   logic [XLEN-1:0]     fetch_pc;
   logic                fetch_stall;
   logic                pred_taken;
   logic [XLEN-1:0]     pred_pc;
   logic [GHR_BITS-1:0] pred_ghr;
   logic                upd_valid;
   logic                upd_is_cond;
   logic [XLEN-1:0]     upd_pc;
   logic [XLEN-1:0]     upd_target;
   logic                upd_taken;
   logic [GHR_BITS-1:0] upd_ghr;
   logic                upd_miss;

   assign fetch_pc_unused_guard = 1'b0;

   modport master (
      output fetch_pc, fetch_stall,
      output upd_valid, upd_is_cond, upd_pc, upd_target, upd_taken, upd_ghr, upd_miss,
      input  pred_taken, pred_pc, pred_ghr
   );

   modport slave (
      input  fetch_pc, fetch_stall,
      input  upd_valid, upd_is_cond, upd_pc, upd_target, upd_taken, upd_ghr, upd_miss,
      output pred_taken, pred_pc, pred_ghr
   );
endinterface

// File: rtl/bp_pht.sv
// Pattern history table: one saturating counter per entry, MSB read combinationally.
module bp_pht
   import bp_pkg::*;
#(
   parameter int unsigned ENTRIES  = 32,
   parameter int unsigned CTR_BITS = 2,
   parameter int unsigned IDX      = $clog2(ENTRIES)
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [IDX-1:0] rd_idx,
   output logic           rd_msb_c,
   input  logic           wr_en,
   input  logic [IDX-1:0] wr_idx,
   input  logic           wr_taken
);
   logic [CTR_BITS-1:0] ctr_q [ENTRIES];
   logic [CTR_BITS-1:0] ctr_d [ENTRIES];

   always_comb begin
      ctr_d = ctr_q;
      if (wr_en) begin
         ctr_d[wr_idx] = CTR_BITS'(ctr_next(bp_ctr_t'(ctr_q[wr_idx]), wr_taken, CTR_BITS));
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < ENTRIES; i++) begin
            ctr_q[i] <= CTR_BITS'(ctr_init(CTR_BITS));
         end
      end else begin
         ctr_q <= ctr_d;
      end
   end

   // Reads see pre-edge contents, so a same-cycle update is not forwarded.
   assign rd_msb_c = ctr_q[rd_idx][CTR_BITS-1];
endmodule

// File: rtl/gshare_predictor.sv
// BTB + PHT direction predictor with speculative global history and miss-time restore.
module gshare_predictor
   import bp_pkg::*;
#(
   parameter int unsigned XLEN     = BP_XLEN,
   parameter int unsigned ENTRIES  = 32,
   parameter int unsigned GHR_BITS = 5,
   parameter int unsigned CTR_BITS = 2,
   parameter int unsigned MODE     = BP_GSHARE
) (
   input logic               clk,
   input logic               reset,
   gshare_predictor_if.slave bp
);
   localparam int unsigned IDX = $clog2(ENTRIES);

   btb_entry_t          btb_q [ENTRIES];
   btb_entry_t          btb_d [ENTRIES];
   logic [GHR_BITS-1:0] ghr_q;
   logic [GHR_BITS-1:0] ghr_d;
   logic [IDX-1:0]      f_idx;
   logic [IDX-1:0]      u_idx;
   logic [IDX-1:0]      f_pht_idx;
   logic [IDX-1:0]      u_pht_idx;
   btb_entry_t          f_ent;
   logic                f_hit;
   logic                u_hit;
   logic                pht_msb;
   logic                taken_c;
   logic [1:0]          unused_upd_pc_lsb;

   function automatic logic [IDX-1:0] pht_index(input logic [IDX-1:0]      idx,
                                                input logic [GHR_BITS-1:0] hist);
      return (MODE == BP_GSHARE) ? (idx ^ IDX'(hist)) : idx;
   endfunction

   // Fetch-side and update-side BTB lookups.
   always_comb begin
      f_idx     = bp.fetch_pc[IDX+1:2];
      f_ent     = btb_q[f_idx];
      f_hit     = f_ent.valid && (f_ent.tag == BP_XLEN'(bp.fetch_pc[XLEN-1:IDX+2]));
      f_pht_idx = pht_index(f_idx, ghr_q);
      u_idx     = bp.upd_pc[IDX+1:2];
      u_hit     = btb_q[u_idx].valid &&
                  (btb_q[u_idx].tag == BP_XLEN'(bp.upd_pc[XLEN-1:IDX+2]));
      u_pht_idx = pht_index(u_idx, bp.upd_ghr);
   end

   assign taken_c           = f_hit && (!f_ent.is_cond || pht_msb);
   assign bp.pred_taken     = taken_c;
   assign bp.pred_pc        = taken_c ? XLEN'(f_ent.target) : (bp.fetch_pc + XLEN'(4));
   assign bp.pred_ghr       = ghr_q;
   assign unused_upd_pc_lsb = bp.upd_pc[1:0];

   // History shift on predicted conditionals; a resolved miss overrides it.
   always_comb begin
      btb_d = btb_q;
      ghr_d = ghr_q;
      if (!bp.fetch_stall && f_hit && f_ent.is_cond) begin
         ghr_d = (ghr_q << 1) | GHR_BITS'(taken_c);
      end
      if (bp.upd_valid && bp.upd_miss) begin
         ghr_d = bp.upd_is_cond ? ((bp.upd_ghr << 1) | GHR_BITS'(bp.upd_taken)) : bp.upd_ghr;
      end
      if (bp.upd_valid && (bp.upd_taken || u_hit)) begin
         btb_d[u_idx] = '{valid:   1'b1,
                          tag:     BP_XLEN'(bp.upd_pc[XLEN-1:IDX+2]),
                          target:  BP_XLEN'(bp.upd_target),
                          is_cond: bp.upd_is_cond};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ghr_q <= '0;
         for (int unsigned i = 0; i < ENTRIES; i++) begin
            btb_q[i] <= '0;
         end
      end else begin
         ghr_q <= ghr_d;
         btb_q <= btb_d;
      end
   end

   bp_pht #(
      .ENTRIES  (ENTRIES),
      .CTR_BITS (CTR_BITS),
      .IDX      (IDX)
   ) u_pht (
      .clk      (clk),
      .reset    (reset),
      .rd_idx   (f_pht_idx),
      .rd_msb_c (pht_msb),
      .wr_en    (bp.upd_valid && bp.upd_is_cond),
      .wr_idx   (u_pht_idx),
      .wr_taken (bp.upd_taken)
   );
endmodule
